// File: rtl/pz_coeff_if.sv
// Byte-stream handshake into the pole/zero coefficient loader.
interface pz_coeff_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/pz_coeff_loader.sv
// Parses SYNC/ADDR/payload/CSUM packets into 8 shadow coefficient words
// and moves them to the active outputs on the first frame_start after a commit.
module pz_coeff_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  pz_coeff_if.slave   in_if,
  input  logic        frame_start,
  output logic [31:0] zero_0,
  output logic [31:0] zero_1,
  output logic [31:0] zero_2,
  output logic [31:0] zero_3,
  output logic [31:0] pole_0,
  output logic [31:0] pole_1,
  output logic [31:0] pole_2,
  output logic [31:0] pole_3,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic        commit_pend
);
  localparam int NUM_SLOTS = 8;
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ADDR, PAYLOAD, CHECK, WRITE} state_e;

  state_e                        state_q, state_d;
  logic [7:0]                    addr_q, addr_d;
  logic [7:0]                    csum_q, csum_d;
  logic [31:0]                   asm_q, asm_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic [NUM_SLOTS-1:0][31:0]    shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0][31:0]    active_q, active_d;
  logic                          pkt_ok_q, pkt_ok_d;
  logic                          pkt_err_q, pkt_err_d;
  logic                          commit_pend_q, commit_pend_d;

  logic acc, in_pkt, tmo_hit, addr_bad, csum_ok;

  assign acc      = in_if.in_valid & in_if.in_ready;
  assign in_pkt   = (state_q == ADDR) || (state_q == PAYLOAD) || (state_q == CHECK);
  assign tmo_hit  = in_pkt && !acc && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign addr_bad = (in_if.in_data[6:3] != 4'd0);
  assign csum_ok  = (in_if.in_data == csum_q);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (acc && in_if.in_data == SYNC_BYTE) state_d = ADDR;
        ADDR:    if (acc) state_d = addr_bad ? IDLE : (in_if.in_data[7] ? CHECK : PAYLOAD);
        PAYLOAD: if (acc && cnt_q == 2'd3) state_d = CHECK;
        CHECK:   if (acc) state_d = csum_ok ? WRITE : IDLE;
        WRITE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath / registered-output next values
  always_comb begin
    addr_d        = addr_q;
    csum_d        = csum_q;
    asm_d         = asm_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_pend_d = commit_pend_q;
    pkt_ok_d      = 1'b0;
    pkt_err_d     = tmo_hit;
    tmo_d         = (acc || !in_pkt) ? '0 : tmo_q + TW'(1);

    case (state_q)
      ADDR: if (acc) begin
        addr_d    = in_if.in_data;
        csum_d    = in_if.in_data;
        cnt_d     = 2'd0;
        pkt_err_d = addr_bad;
      end
      PAYLOAD: if (acc) begin
        asm_d  = {asm_q[23:0], in_if.in_data};
        csum_d = csum_q ^ in_if.in_data;
        cnt_d  = cnt_q + 2'd1;
      end
      CHECK: if (acc) begin
        pkt_ok_d  = csum_ok;
        pkt_err_d = !csum_ok;
      end
      default: ;
    endcase

    // Copy reads shadow_q, so a same-cycle shadow write lands after the copy.
    if (frame_start && commit_pend_q) begin
      active_d      = shadow_q;
      commit_pend_d = 1'b0;
    end

    // A commit landing with frame_start stays pending for the next frame.
    if (state_q == WRITE) begin
      if (addr_q[7]) commit_pend_d = 1'b1;
      else           shadow_d[addr_q[2:0]] = asm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q        <= '0;
      csum_q        <= '0;
      asm_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pkt_ok_q      <= 1'b0;
      pkt_err_q     <= 1'b0;
      commit_pend_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      csum_q        <= csum_d;
      asm_q         <= asm_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pkt_ok_q      <= pkt_ok_d;
      pkt_err_q     <= pkt_err_d;
      commit_pend_q <= commit_pend_d;
    end
  end

  // outputs
  always_comb begin
    in_if.in_ready = rst_n && (state_q != WRITE);
    zero_0         = active_q[0];
    zero_1         = active_q[1];
    zero_2         = active_q[2];
    zero_3         = active_q[3];
    pole_0         = active_q[4];
    pole_1         = active_q[5];
    pole_2         = active_q[6];
    pole_3         = active_q[7];
    pkt_ok         = pkt_ok_q;
    pkt_err        = pkt_err_q;
    commit_pend    = commit_pend_q;
  end
endmodule

// File: tb/tb_pz_coeff_loader.sv
// Directed bench for pz_coeff_loader: packet results go through an expectation
// queue; active coefficient words are compared against a bench-side table.
module tb_pz_coeff_loader;
  typedef logic [7:0] bq_t[$];
  localparam logic [1:0] OK  = 2'b10;
  localparam logic [1:0] ERR = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [31:0] zero_0, zero_1, zero_2, zero_3, pole_0, pole_1, pole_2, pole_3;
  logic        pkt_ok, pkt_err, commit_pend;
  logic [31:0] act_o [8];
  logic [31:0] exp_act [8];
  logic [1:0]  exp_q[$];
  int          total = 0;
  int          bad   = 0;

  pz_coeff_if bus();

  pz_coeff_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(bus), .frame_start(frame_start),
    .zero_0(zero_0), .zero_1(zero_1), .zero_2(zero_2), .zero_3(zero_3),
    .pole_0(pole_0), .pole_1(pole_1), .pole_2(pole_2), .pole_3(pole_3),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .commit_pend(commit_pend)
  );

  always #5 clk = ~clk;

  always_comb begin
    act_o[0] = zero_0; act_o[1] = zero_1; act_o[2] = zero_2; act_o[3] = zero_3;
    act_o[4] = pole_0; act_o[5] = pole_1; act_o[6] = pole_2; act_o[7] = pole_3;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_act(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_act%0d", tag, i), act_o[i], exp_act[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Result is sampled the cycle after the final byte; fs_on_write raises
  // frame_start during that cycle so it coincides with the WRITE state.
  task automatic send_pkt(input string tag, input bq_t b, input logic [1:0] res, input bit fs_on_write);
    logic [1:0] e;
    exp_q.push_back(res);
    foreach (b[i]) send_byte(b[i]);
    e = exp_q.pop_front();
    chk({tag, "_res"}, {30'd0, pkt_ok, pkt_err}, {30'd0, e});
    if (fs_on_write) frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    chk({tag, "_pulse1"}, {30'd0, pkt_ok, pkt_err}, 32'd0);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0] e;
    rst_n        = 1'b0;
    frame_start  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    foreach (exp_act[i]) exp_act[i] = 32'd0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_flags", {29'd0, pkt_ok, pkt_err, commit_pend}, 32'd0);
    chk_act("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1: write zero_2, commit, frame_start
    send_pkt("t1_wr", '{8'hA5, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h00, 8'hFC}, OK, 0);
    send_pkt("t1_cm", '{8'hA5, 8'h80, 8'h80}, OK, 0);
    chk("t1_pend", {31'd0, commit_pend}, 32'd1);
    chk_act("t1_pre");
    pulse_frame();
    exp_act[2] = 32'h0100FF00;
    chk_act("t1_post");
    chk("t1_pend_clr", {31'd0, commit_pend}, 32'd0);

    // 2: bad checksum to pole_1, reserved address bits
    send_pkt("t2_bad", '{8'hA5, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00}, ERR, 0);
    send_pkt("t2_rsv", '{8'hA5, 8'h08}, ERR, 0);
    send_pkt("t2_cm", '{8'hA5, 8'h80, 8'h80}, OK, 0);
    pulse_frame();
    chk_act("t2");

    // 3: commit first, then stall mid-packet into timeout, then a good write
    send_pkt("t3_cm", '{8'hA5, 8'h80, 8'h80}, OK, 0);
    exp_q.push_back(ERR);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11);
    n = 0;
    while (!pkt_err && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t3_tmo_cycles", n, 32'd16);
    e = exp_q.pop_front();
    chk("t3_tmo_res", {30'd0, pkt_ok, pkt_err}, {30'd0, e});
    send_pkt("t3_wr", '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40}, OK, 0);
    chk("t3_pend", {31'd0, commit_pend}, 32'd1);
    pulse_frame();
    exp_act[4] = 32'h11223344;
    chk_act("t3");

    // 4: SYNC value inside payload is data
    send_pkt("t4_wr", '{8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00}, OK, 0);
    send_pkt("t4_cm", '{8'hA5, 8'h80, 8'h80}, OK, 0);
    pulse_frame();
    exp_act[0] = 32'hA5A50000;
    chk_act("t4");

    // 5: commit WRITE coincident with frame_start
    send_pkt("t5_wr", '{8'hA5, 8'h06, 8'hCA, 8'hFE, 8'h00, 8'h01, 8'h33}, OK, 0);
    send_pkt("t5_cm", '{8'hA5, 8'h80, 8'h80}, OK, 1);
    chk("t5_pend", {31'd0, commit_pend}, 32'd1);
    chk_act("t5_pre");
    pulse_frame();
    exp_act[6] = 32'hCAFE0001;
    chk_act("t5_post");
    chk("t5_pend_clr", {31'd0, commit_pend}, 32'd0);

    // 6: reset mid-packet with a commit pending
    send_pkt("t6_cm", '{8'hA5, 8'h80, 8'h80}, OK, 0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h7F);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (exp_act[i]) exp_act[i] = 32'd0;
    chk_act("t6_rst");
    chk("t6_flags", {29'd0, pkt_ok, pkt_err, commit_pend}, 32'd0);
    send_pkt("t6_wr", '{8'hA5, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21}, OK, 0);
    send_pkt("t6_cm2", '{8'hA5, 8'h80, 8'h80}, OK, 0);
    pulse_frame();
    exp_act[3] = 32'hDEADBEEF;
    chk_act("t6");

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
